mul_div_unit: RTL and testbench



---
 rtl/mul_div_unit.sv | 176 +++++++++++++++++
 tb/tb_mul_div_unit.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// mul_div_unit - multi-cycle multiply/divide responder for the execute stage.
//
// Multiply finishes in one cycle. Divide is a 32-step radix-2 restoring
// iteration with a sign fixup on the last step. The result is presented on
// hi/lo together with a one-cycle done pulse.
//
// Optional feature macro: MDU_DIV_ZERO_EN
//   When defined, a divide by zero short-circuits straight to DONE and the
//   div_zero output is present.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-low reset
//   start     in   mul/div instruction present in E (level, held while stalled)
//   mul_div   in   0 = multiply, 1 = divide
//   is_sign   in   1 = signed, 0 = unsigned
//   flush     in   E-stage flush, aborts any operation
//   src_a     in   multiplicand / dividend
//   src_b     in   multiplier / divisor
//   stall     out  pipeline hold request (combinational)
//   done      out  one-cycle result pulse
//   hi        out  product[63:32] or remainder
//   lo        out  product[31:0] or quotient
//   div_zero  out  divisor was zero (MDU_DIV_ZERO_EN only)
//   dbgState  out  current FSM state (0 IDLE, 1 DIV, 2 DONE)
//
// Handshake: start acts as "valid" and ~stall as "ready". A request is
// accepted in the IDLE cycle where start=1 and flush=0; the pipeline keeps
// start and the operands steady for as long as stall is high. The instruction
// leaves E at the end of the DONE cycle, so its still-high start is ignored.
module mul_div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        mul_div,
    input  logic        is_sign,
    input  logic        flush,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        stall,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
`ifdef MDU_DIV_ZERO_EN
    output logic        div_zero,
`endif
    output logic [1:0]  dbgState
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] DIV  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state;
    logic [31:0] hiReg;
    logic [31:0] loReg;
    logic [31:0] remReg;
    logic [31:0] quoReg;
    logic [31:0] divisorReg;
    logic [4:0]  cnt;
    logic        negQuo;
    logic        negRem;
`ifdef MDU_DIV_ZERO_EN
    logic        divZeroReg;
`endif

    // Multiply: sign-extending to 64 bits makes the low 64 bits of an
    // unsigned multiply equal the signed product, so one multiplier serves both.
    logic        extA;
    logic        extB;
    logic [63:0] product;
    logic [31:0] absA;
    logic [31:0] absB;

    always_comb begin
        extA    = is_sign & src_a[31];
        extB    = is_sign & src_b[31];
        product = {{32{extA}}, src_a} * {{32{extB}}, src_b};
        absA    = extA ? (32'd0 - src_a) : src_a;
        absB    = extB ? (32'd0 - src_b) : src_b;
    end

    // One restoring step. The remainder stays below the divisor, so the
    // shifted partial remainder fits in 33 bits and bit 32 of the trial
    // subtraction is the borrow.
    logic [32:0] trial;
    logic [31:0] remNext;
    logic [31:0] quoNext;

    always_comb begin
        trial = {remReg, quoReg[31]} - {1'b0, divisorReg};
        if (!trial[32]) begin
            remNext = trial[31:0];
            quoNext = {quoReg[30:0], 1'b1};
        end else begin
            remNext = {remReg[30:0], quoReg[31]};
            quoNext = {quoReg[30:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            hiReg      <= 32'd0;
            loReg      <= 32'd0;
            remReg     <= 32'd0;
            quoReg     <= 32'd0;
            divisorReg <= 32'd0;
            cnt        <= 5'd0;
            negQuo     <= 1'b0;
            negRem     <= 1'b0;
`ifdef MDU_DIV_ZERO_EN
            divZeroReg <= 1'b0;
`endif
        end else begin
`ifdef MDU_DIV_ZERO_EN
            // Set only on the IDLE->DONE zero-divisor edge, so high exactly in DONE.
            divZeroReg <= 1'b0;
`endif
            if (flush) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            if (!mul_div) begin
                                hiReg <= product[63:32];
                                loReg <= product[31:0];
                                state <= DONE;
                            end
`ifdef MDU_DIV_ZERO_EN
                            else if (src_b == 32'd0) begin
                                hiReg      <= src_a;
                                loReg      <= 32'hFFFF_FFFF;
                                divZeroReg <= 1'b1;
                                state      <= DONE;
                            end
`endif
                            else begin
                                remReg     <= 32'd0;
                                quoReg     <= absA;
                                divisorReg <= absB;
                                negQuo     <= is_sign & (src_a[31] ^ src_b[31]);
                                negRem     <= is_sign & src_a[31];
                                cnt        <= 5'd0;
                                state      <= DIV;
                            end
                        end
                    end
                    DIV: begin
                        remReg <= remNext;
                        quoReg <= quoNext;
                        cnt    <= cnt + 5'd1;
                        if (cnt == 5'd31) begin
                            hiReg <= negRem ? (32'd0 - remNext) : remNext;
                            loReg <= negQuo ? (32'd0 - quoNext) : quoNext;
                            state <= DONE;
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign stall    = rst & ~flush & (((state == IDLE) & start) | (state == DIV));
    assign done     = (state == DONE);
    assign hi       = hiReg;
    assign lo       = loReg;
    assign dbgState = state;
`ifdef MDU_DIV_ZERO_EN
    assign div_zero = divZeroReg;
`endif

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: directed vector table, hand-written flush/reset
// sequences, then random operations against an arithmetic reference model.
module tb_mul_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        mul_div;
    logic        is_sign;
    logic        flush;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        stall;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [1:0]  dbgState;
`ifdef MDU_DIV_ZERO_EN
    logic        div_zero;
`endif

    mul_div_unit dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mul_div  (mul_div),
        .is_sign  (is_sign),
        .flush    (flush),
        .src_a    (src_a),
        .src_b    (src_b),
        .stall    (stall),
        .done     (done),
        .hi       (hi),
        .lo       (lo),
`ifdef MDU_DIV_ZERO_EN
        .div_zero (div_zero),
`endif
        .dbgState (dbgState)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int checks;
    int errors;
    logic [31:0] prevHi;
    logic [31:0] prevLo;
    logic [31:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: plain arithmetic on the operation's meaning.
    task automatic ref_model(input logic md, input logic sg, input logic [31:0] a,
                             input logic [31:0] b, output logic [31:0] eh, output logic [31:0] el);
        longint sa;
        longint sb;
        longint q;
        longint r;
        logic [63:0] p;
        sa = sg ? longint'($signed(a)) : longint'({32'd0, a});
        sb = sg ? longint'($signed(b)) : longint'({32'd0, b});
        if (!md) begin
            p  = 64'(sa * sb);
            eh = p[63:32];
            el = p[31:0];
        end else if (b == 32'd0) begin
            eh = a;
            el = 32'hFFFF_FFFF;
        end else begin
            q  = sa / sb;
            r  = sa % sb;
            eh = r[31:0];
            el = q[31:0];
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            start = 1'b0;
            flush = 1'b0;
            #1;
            chk("idle_done", done, 1'b0);
            chk("idle_stall", stall, 1'b0);
            chk("idle_hi_hold", hi, prevHi);
            chk("idle_lo_hold", lo, prevLo);
        end
    endtask

    // Issue one operation and follow it cycle by cycle. flushAt>0 flushes
    // in that cycle after acceptance and abandons the operation.
    task automatic do_op(input logic md, input logic sg, input logic [31:0] a,
                         input logic [31:0] b, input int flushAt);
        logic [31:0] eh;
        logic [31:0] el;
        logic        edz;
        int          lat;
        ref_model(md, sg, a, b, eh, el);
        exp_q.push_back(eh);
        exp_q.push_back(el);
        edz = 1'b0;
        lat = md ? 33 : 1;
`ifdef MDU_DIV_ZERO_EN
        if (md && b == 32'd0) begin
            lat = 1;
            edz = 1'b1;
        end
`endif
        @(negedge clk);
        start   = 1'b1;
        flush   = 1'b0;
        mul_div = md;
        is_sign = sg;
        src_a   = a;
        src_b   = b;
        #1;
        chk("stall_accept", stall, 1'b1);
        chk("done_accept", done, 1'b0);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            if (k == flushAt) begin
                flush = 1'b1;
                #1;
                chk("flush_stall", stall, 1'b0);
                chk("flush_done", done, 1'b0);
                chk("flush_hi_hold", hi, prevHi);
                chk("flush_lo_hold", lo, prevLo);
                void'(exp_q.pop_back());
                void'(exp_q.pop_back());
                return;
            end
            #1;
            if (k < lat) begin
                chk("busy_stall", stall, 1'b1);
                chk("busy_done", done, 1'b0);
                chk("busy_hi_hold", hi, prevHi);
                chk("busy_lo_hold", lo, prevLo);
            end else begin
                chk("result_done", done, 1'b1);
                chk("result_stall", stall, 1'b0);
                chk("result_hi", hi, exp_q.pop_front());
                chk("result_lo", lo, exp_q.pop_front());
`ifdef MDU_DIV_ZERO_EN
                chk("result_div_zero", div_zero, edz);
`endif
            end
        end
        if (edz) prevHi = eh; // keeps edz referenced in every build
        prevHi = eh;
        prevLo = el;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        md;
        logic        sg;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eh;
        logic [31:0] el;
    } vec_t;

    vec_t vecs[11];

    initial begin
        checks  = 0;
        errors  = 0;
        prevHi  = 32'd0;
        prevLo  = 32'd0;

        vecs[0]  = '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE};
        vecs[1]  = '{1'b0, 1'b1, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
        vecs[2]  = '{1'b1, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3]  = '{1'b1, 1'b0, 32'd100,       32'd7,         32'd2,        32'd14};
        vecs[4]  = '{1'b0, 1'b0, 32'd3,         32'd4,         32'd0,        32'd12};
        vecs[5]  = '{1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[6]  = '{1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[7]  = '{1'b1, 1'b1, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[8]  = '{1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF};
        vecs[9]  = '{1'b1, 1'b0, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF};
        vecs[10] = '{1'b1, 1'b0, 32'd5,         32'd0,         32'd5,        32'hFFFF_FFFF};

        // ---- reset, with start high to show stall is held low ----
        rst     = 1'b0;
        start   = 1'b1;
        flush   = 1'b0;
        mul_div = 1'b0;
        is_sign = 1'b0;
        src_a   = 32'd3;
        src_b   = 32'd4;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_stall", stall, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
`ifdef MDU_DIV_ZERO_EN
        chk("reset_div_zero", div_zero, 1'b0);
`endif
        rst   = 1'b1;
        start = 1'b0;
        idle(2);

        // ---- table, issued back to back (DIVU 100/7 then MULTU 3*4) ----
        for (int i = 0; i < 11; i++) begin
            do_op(vecs[i].md, vecs[i].sg, vecs[i].a, vecs[i].b, 0);
            chk("table_hi", hi, vecs[i].eh);
            chk("table_lo", lo, vecs[i].el);
        end
        idle(2);

        // ---- flush mid-divide, then a new divide right behind it ----
        do_op(1'b1, 1'b0, 32'd100, 32'd7, 10);
        do_op(1'b1, 1'b0, 32'd9, 32'd2, 0);
        chk("after_flush_hi", hi, 32'd1);
        chk("after_flush_lo", lo, 32'd4);
        idle(2);

        // ---- flush and start together: nothing accepted ----
        @(negedge clk);
        start   = 1'b1;
        flush   = 1'b1;
        mul_div = 1'b0;
        is_sign = 1'b0;
        src_a   = 32'd5;
        src_b   = 32'd6;
        #1;
        chk("flush_start_stall", stall, 1'b0);
        idle(3);

        // ---- reset in the middle of a divide ----
        @(negedge clk);
        start   = 1'b1;
        mul_div = 1'b1;
        is_sign = 1'b0;
        src_a   = 32'd100;
        src_b   = 32'd7;
        repeat (6) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midreset_stall", stall, 1'b0);
        @(negedge clk);
        #1;
        chk("midreset_done", done, 1'b0);
        chk("midreset_hi", hi, 32'd0);
        chk("midreset_lo", lo, 32'd0);
        rst    = 1'b1;
        start  = 1'b0;
        prevHi = 32'd0;
        prevLo = 32'd0;
        idle(40);

        // ---- random operations against the reference model ----
        for (int n = 0; n < 60; n++) begin
            logic        md;
            logic        sg;
            logic [31:0] a;
            logic [31:0] b;
            md = 1'($urandom_range(0, 1));
            sg = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 9));
                2:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
                default: b = $urandom;
            endcase
`ifndef MDU_DIV_ZERO_EN
            // Signed divide by zero has no defined result without the feature.
            if (md && sg && b == 32'd0) b = 32'd1;
`endif
            do_op(md, sg, a, b, 0);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(2);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
